// File: rtl/cpu_decode_q.sv
// cpu_decode_q: decodes moxie opcodes at enqueue and buffers them in a DEPTH-entry FIFO for execute
module cpu_decode_q #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32,
   parameter int OFS_W = 10
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         flush_i,
   input  logic                         valid_i,
   output logic                         ready_o,
   input  logic [15:0]                  opcode_i,
   input  logic [31:0]                  operand_i,
   input  logic [PC_W-1:0]              PC_i,
   output logic                         valid_o,
   input  logic                         ready_i,
   output logic [6:0]                   op_o,
   output logic [3:0]                   riA_o,
   output logic [3:0]                   riB_o,
   output logic [31:0]                  operand_o,
   output logic [OFS_W-1:0]             pcrel_offset_o,
   output logic                         illegal_o,
   output logic [PC_W-1:0]              PC_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   typedef struct packed {
      logic [6:0]       op;
      logic [3:0]       ria;
      logic [3:0]       rib;
      logic [31:0]      operand;
      logic [OFS_W-1:0] ofs;
      logic             ill;
      logic [PC_W-1:0]  pc;
   } entry_t;
   entry_t mem [DEPTH];
   entry_t dec, head, hold, cur;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [5:0] o6;
   logic [3:0] cc;
   logic f1_ill, f1_opd, push, pop;
   assign o6     = opcode_i[13:8];
   assign cc     = opcode_i[13:10];
   assign f1_ill = (o6 >= 6'h0F && o6 <= 6'h18) || o6 >= 6'h3A;
   assign f1_opd = o6 inside {6'h01, 6'h03, 6'h08, 6'h09, 6'h1A};
   always_comb begin
      dec         = '0;
      dec.pc      = PC_i;
      dec.ofs     = opcode_i[OFS_W-1:0];
      dec.rib     = opcode_i[3:0];
      dec.ria     = opcode_i[15] ? opcode_i[11:8] : opcode_i[7:4];
      case (opcode_i[15:14])
         2'b00: begin
            dec.ill     = f1_ill;
            dec.op      = f1_ill ? 7'h7F : {1'b0, o6};
            dec.operand = f1_opd ? operand_i : 32'h0;
         end
         2'b01: begin
            dec.ill = 1'b1;
            dec.op  = 7'h7F;
         end
         2'b10: begin
            dec.op      = {5'b10000, opcode_i[13:12]};
            dec.operand = {24'h0, opcode_i[7:0]};
         end
         default: begin
            dec.ill = cc > 4'd9;
            dec.op  = (cc > 4'd9) ? 7'h7F : {3'b101, cc};
         end
      endcase
   end
   assign valid_o = count != '0;
   assign ready_o = rst_i && count != FULL && !flush_i;
   assign push    = valid_i && ready_o;
   assign pop     = valid_o && ready_i;
   assign head    = mem[rd_ptr];
   assign cur     = valid_o ? head : hold;
   assign op_o           = valid_o ? head.op : 7'h00;
   assign illegal_o      = valid_o && head.ill;
   assign riA_o          = cur.ria;
   assign riB_o          = cur.rib;
   assign operand_o      = cur.operand;
   assign pcrel_offset_o = cur.ofs;
   assign PC_o           = cur.pc;
   assign count_o        = count;
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= dec;
   end
   // hold tracks the visible head so an empty queue keeps showing the last entry read
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         hold   <= '0;
      end else begin
         if (valid_o) hold <= head;
         if (flush_i) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end
endmodule

// File: tb/tb_cpu_decode_q.sv
// tb_cpu_decode_q: directed and randomized checks of cpu_decode_q against a queue-based decode model
module tb_cpu_decode_q;
   localparam int DEPTH = 4;
   logic        clk_i = 0, rst_i = 0, flush_i = 0, valid_i = 0, ready_i = 0;
   logic [15:0] opcode_i = '0;
   logic [31:0] operand_i = '0, PC_i = '0;
   logic        ready_o, valid_o, illegal_o;
   logic [6:0]  op_o;
   logic [3:0]  riA_o, riB_o;
   logic [31:0] operand_o, PC_o;
   logic [9:0]  pcrel_offset_o;
   logic [2:0]  count_o;
   int checks = 0, errors = 0;
   logic [31:0] pc = 32'h2000;

   cpu_decode_q #(.DEPTH(DEPTH), .PC_W(32), .OFS_W(10)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
      .opcode_i(opcode_i), .operand_i(operand_i), .PC_i(PC_i), .valid_o(valid_o), .ready_i(ready_i),
      .op_o(op_o), .riA_o(riA_o), .riB_o(riB_o), .operand_o(operand_o),
      .pcrel_offset_o(pcrel_offset_o), .illegal_o(illegal_o), .PC_o(PC_o), .count_o(count_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [6:0]  op;
      logic [3:0]  ria, rib;
      logic [31:0] opd;
      logic [9:0]  ofs;
      logic        ill;
      logic [31:0] pc;
      bit          chk_regs, chk_opd;
   } exp_t;

   exp_t q[$];
   exp_t hold;
   bit   hold_known = 0;
   bit   m_push, m_pop;

   function automatic exp_t model_dec(input logic [15:0] opc, input logic [31:0] opd, input logic [31:0] a);
      exp_t e;
      int code;
      e = '{default: '0};
      e.pc = a;
      e.ofs = opc[9:0];
      e.chk_regs = 1;
      e.chk_opd = 1;
      case (opc[15:14])
         2'd0: begin
            code = int'(opc[13:8]);
            e.ria = opc[7:4];
            e.rib = opc[3:0];
            if ((code >= 15 && code <= 24) || code >= 58) begin
               e.op = 7'h7F;
               e.ill = 1;
            end else e.op = 7'(code);
            if (code == 1 || code == 3 || code == 8 || code == 9 || code == 26) e.opd = opd;
         end
         2'd1: begin
            e.op = 7'h7F;
            e.ill = 1;
            e.chk_regs = 0;
            e.chk_opd = 0;
         end
         2'd2: begin
            e.op = 7'(64 + int'(opc[13:12]));
            e.ria = opc[11:8];
            e.rib = opc[3:0];
            e.opd = 32'(opc[7:0]);
         end
         default: begin
            code = int'(opc[13:10]);
            e.ria = opc[11:8];
            e.rib = opc[3:0];
            e.chk_opd = 0;
            if (code <= 9) e.op = 7'(80 + code);
            else begin
               e.op = 7'h7F;
               e.ill = 1;
            end
         end
      endcase
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
      end
   endtask

   task automatic cmp_fields(input exp_t e);
      if (e.chk_regs) begin
         chk("riA_o", 64'(riA_o), 64'(e.ria));
         chk("riB_o", 64'(riB_o), 64'(e.rib));
      end
      if (e.chk_opd) chk("operand_o", 64'(operand_o), 64'(e.opd));
      chk("pcrel_offset_o", 64'(pcrel_offset_o), 64'(e.ofs));
      chk("PC_o", 64'(PC_o), 64'(e.pc));
   endtask

   // reference queue: one entry per accepted instruction, cleared by flush and reset
   always @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         q.delete();
         hold = '{default: '0};
         hold.chk_regs = 1;
         hold.chk_opd = 1;
         hold_known = 1;
      end else if (flush_i) begin
         if (q.size() != 0) hold_known = 0;
         q.delete();
      end else begin
         m_push = valid_i && q.size() < DEPTH;
         m_pop  = q.size() != 0 && ready_i;
         if (m_pop) begin
            hold = q.pop_front();
            hold_known = 1;
         end
         if (m_push) q.push_back(model_dec(opcode_i, operand_i, PC_i));
      end
   end

   always @(negedge clk_i) begin
      chk("ready_o", 64'(ready_o), 64'(rst_i && q.size() < DEPTH && !flush_i));
      chk("count_o", 64'(count_o), 64'(q.size()));
      chk("valid_o", 64'(valid_o), 64'(q.size() != 0));
      if (q.size() != 0) begin
         chk("op_o", 64'(op_o), 64'(q[0].op));
         chk("illegal_o", 64'(illegal_o), 64'(q[0].ill));
         cmp_fields(q[0]);
      end else begin
         chk("op_o_empty", 64'(op_o), 64'h0);
         chk("illegal_o_empty", 64'(illegal_o), 64'h0);
         if (hold_known) cmp_fields(hold);
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_in(input logic [15:0] opc);
      opcode_i  = opc;
      operand_i = $urandom;
      pc        = pc + 2;
      PC_i      = pc;
   endtask

   initial begin
      repeat (3) step();
      rst_i = 1;
      valid_i = 1;
      opcode_i = 16'h0123;
      operand_i = 32'hDEADBEEF;
      PC_i = 32'h1000;
      @(negedge clk_i);
      chk("lit_ready_after_reset", 64'(ready_o), 64'h1);
      chk("lit_count_after_reset", 64'(count_o), 64'h0);
      step();
      valid_i = 0;
      @(negedge clk_i);
      chk("lit_first_valid", 64'(valid_o), 64'h1);
      chk("lit_first_op", 64'(op_o), 64'h01);
      chk("lit_first_riA", 64'(riA_o), 64'h2);
      chk("lit_first_riB", 64'(riB_o), 64'h3);
      chk("lit_first_operand", 64'(operand_o), 64'hDEADBEEF);
      chk("lit_first_pc", 64'(PC_o), 64'h1000);
      chk("lit_first_count", 64'(count_o), 64'h1);
      step();
      valid_i = 1;
      set_in(16'h8A05);
      step();
      set_in(16'hC3FF);
      step();
      set_in(16'h0F00);
      step();
      set_in(16'h1234);
      @(negedge clk_i);
      chk("lit_full_count", 64'(count_o), 64'h4);
      chk("lit_full_ready", 64'(ready_o), 64'h0);
      step();
      valid_i = 0;
      ready_i = 1;
      step();
      @(negedge clk_i);
      chk("lit_inc_op", 64'(op_o), 64'h40);
      chk("lit_inc_riA", 64'(riA_o), 64'hA);
      chk("lit_inc_operand", 64'(operand_o), 64'h5);
      chk("lit_drain_count", 64'(count_o), 64'h3);
      step();
      @(negedge clk_i);
      chk("lit_beq_op", 64'(op_o), 64'h50);
      chk("lit_beq_ofs", 64'(pcrel_offset_o), 64'h3FF);
      step();
      @(negedge clk_i);
      chk("lit_ill0f_op", 64'(op_o), 64'h7F);
      chk("lit_ill0f_flag", 64'(illegal_o), 64'h1);
      step();
      @(negedge clk_i);
      chk("lit_empty_valid", 64'(valid_o), 64'h0);
      chk("lit_empty_op", 64'(op_o), 64'h0);
      step();
      ready_i = 0;
      valid_i = 1;
      set_in(16'h4000);
      step();
      set_in(16'hE800);
      step();
      set_in(16'h0100);
      step();
      valid_i = 0;
      @(negedge clk_i);
      chk("lit_ill40_op", 64'(op_o), 64'h7F);
      chk("lit_ill40_flag", 64'(illegal_o), 64'h1);
      step();
      ready_i = 1;
      step();
      ready_i = 0;
      @(negedge clk_i);
      chk("lit_illE8_op", 64'(op_o), 64'h7F);
      chk("lit_illE8_flag", 64'(illegal_o), 64'h1);
      chk("lit_preflush_count", 64'(count_o), 64'h2);
      step();
      valid_i = 1;
      flush_i = 1;
      set_in(16'h0123);
      step();
      flush_i = 0;
      valid_i = 0;
      @(negedge clk_i);
      chk("lit_flush_count", 64'(count_o), 64'h0);
      chk("lit_flush_valid", 64'(valid_o), 64'h0);
      chk("lit_flush_op", 64'(op_o), 64'h0);
      step();
      @(negedge clk_i);
      chk("lit_flush_absent", 64'(count_o), 64'h0);
      step();
      ready_i = 1;
      valid_i = 1;
      set_in(16'($urandom));
      for (int i = 0; i < 12; i++) begin
         step();
         set_in(16'($urandom));
         @(negedge clk_i);
         chk("lit_stream_count", 64'(count_o), 64'h1);
      end
      @(posedge clk_i);
      #3 rst_i = 0;
      #1;
      chk("lit_rst_valid", 64'(valid_o), 64'h0);
      chk("lit_rst_ready", 64'(ready_o), 64'h0);
      chk("lit_rst_count", 64'(count_o), 64'h0);
      chk("lit_rst_op", 64'(op_o), 64'h0);
      chk("lit_rst_pc", 64'(PC_o), 64'h0);
      chk("lit_rst_operand", 64'(operand_o), 64'h0);
      step();
      rst_i = 1;
      valid_i = 0;
      ready_i = 0;
      for (int i = 0; i < 3000; i++) begin
         step();
         valid_i = $urandom_range(0, 9) < 7;
         ready_i = $urandom_range(0, 9) < 6;
         flush_i = $urandom_range(0, 19) == 0;
         set_in(16'($urandom));
         if ($urandom_range(0, 399) == 0) begin
            #2 rst_i = 0;
            #1 rst_i = 1;
         end
      end
      step();
      flush_i = 0;
      valid_i = 0;
      @(negedge clk_i);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cpu_decode_q.md
Name: cpu_decode_q

Overview:
- Queued, parametrised decode stage for the mox125 pipeline, sitting between fetch and execute.
- Accepts raw 16-bit moxie opcodes plus a 32-bit operand from fetch over a valid/ready handshake.
- Decodes each instruction fully at enqueue into a normalised op code, register indices, operand and branch offset.
- Buffers up to DEPTH decoded entries, so a stalled execute stage no longer drops or overwrites fetched instructions; a flush empties the queue.

Parameters:
DEPTH, 4, queue entries; power of two, 2..16.
PC_W, 32, program-counter width.
OFS_W, 10, pcrel branch-offset width (max 10).

Ports:
clk_i  in  1  clock, all state on rising edge.
rst_i  in  1  asynchronous, active-low reset.
flush_i  in  1  synchronous queue clear (branch taken / exception).
valid_i  in  1  fetch presents an instruction.
ready_o  out  1  queue can accept this cycle.
opcode_i  in  16  raw opcode.
operand_i  in  32  trailing operand word (don't-care for short forms).
PC_i  in  PC_W  address of opcode.
valid_o  out  1  head entry valid.
ready_i  in  1  execute consumes head this cycle.
op_o  out  7  normalised op.
riA_o  out  4  register A index.
riB_o  out  4  register B index.
operand_o  out  32  operand.
pcrel_offset_o  out  OFS_W  branch offset.
illegal_o  out  1  head is an undefined opcode.
PC_o  out  PC_W  head PC.
count_o  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset (rst_i low, asynchronous):
  - Queue empty; all outputs 0; ready_o 0 while rst_i is low.
  - ready_o = 1 on the first cycle after deassertion.
- Handshake and queue:
  - ready_o = (count < DEPTH) and not flush_i; combinational from registered count.
  - Enqueue when valid_i & ready_o; dequeue when valid_o & ready_i.
  - Enqueue and dequeue in the same edge leave count unchanged. No full-queue bypass: a full queue refuses input even while dequeuing.
  - Latency: an instruction enqueued into an empty queue at edge N appears on the outputs after edge N.
  - Order is strictly FIFO. Read and write pointers wrap modulo DEPTH.
- Output when empty:
  - valid_o = 0, op_o = 7'h00 (NOP), illegal_o = 0.
  - All other outputs hold the last-read value.
  - valid_o = (count != 0).
- Flush:
  - At the edge where flush_i is high, count goes to 0, pointers reset and no enqueue occurs.
  - valid_o is 0 the following cycle.
  - A dequeue in the flush cycle is irrelevant: the queue is cleared anyway.
  - Flush has priority over all other events.
- Decode at enqueue (entry stores decoded fields):
  - Form 1, opcode[15:14] = 00:
    - op = {1'b0, opcode[13:8]}.
    - riA = opcode[7:4], riB = opcode[3:0].
    - operand = operand_i for op 0x01, 0x03, 0x08, 0x09, 0x1A; otherwise 0.
    - Undefined op 0x0F..0x18 and 0x3A..0x3F gives op 7'h7F with illegal = 1.
  - Form 1 opcode[15:14] = 01 is undefined: op 7'h7F, illegal = 1.
  - Form 2, opcode[15:14] = 10:
    - op = 7'h40 + opcode[13:12] (INC 40, DEC 41, GSR 42, SSR 43).
    - riA = opcode[11:8], riB = opcode[3:0].
    - operand = {24'b0, opcode[7:0]}.
  - Form 3, opcode[15:14] = 11:
    - opcode[13:10] of 0..9 gives op = 7'h50 + opcode[13:10] (BEQ 50 .. BLEU 59).
    - opcode[13:10] of 10..15 gives op 7'h7F with illegal = 1.
    - riA = opcode[11:8], riB = opcode[3:0].
  - pcrel_offset = opcode[OFS_W-1:0] for every form.
  - PC stored unchanged.
- count_o is exact occupancy, 0..DEPTH. Overflow and underflow are impossible by construction.
- Reset mid-operation discards all entries immediately.

Test Plan:
- Reset release, valid_i = 1, opcode 16'h0123, operand 32'hDEADBEEF, PC 32'h1000 -> next cycle valid_o = 1, op_o = 7'h01, riA_o = 2, riB_o = 3, operand_o = DEADBEEF, PC_o = 1000, count_o = 1.
- ready_i = 0 while 4 instructions are sent (DEPTH = 4) -> count_o = 4, ready_o = 0, fifth instruction held by fetch; ready_i = 1 then drains entries in order, one per cycle.
- Queue holds 2 entries, flush_i pulsed together with valid_i -> next cycle count_o = 0, valid_o = 0, op_o = 0, the flush-cycle instruction is absent.
- Opcode 16'h8A05 -> op_o = 7'h40, riA_o = 10, operand_o = 32'h5; opcode 16'hC3FF -> op_o = 7'h50, pcrel_offset_o = 10'h3FF.
- Opcodes 16'h0F00, 16'h4000, 16'hE800 -> op_o = 7'h7F and illegal_o = 1 each; no other entry is affected.
- Continuous valid_i = 1 and ready_i = 1 -> count_o stays 1, one instruction per cycle, pointer wrap verified across more than 2*DEPTH instructions; rst_i pulsed low mid-stream -> outputs 0 asynchronously.
